neuron_core_wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter in front of neuron_core.
- Master 0 is the Caravel host bus; master 1 is the on-chip spike/event sequencer. Both share neuron_core's single Wishbone slave port.
- Round-robin grant, held for a whole cyc; optional per-access timeout protects against a hung slave.

---
 rtl/neuron_core_pkg.sv | 15 +
 rtl/nca_rr_pick.sv | 22 ++
 rtl/neuron_core_wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_neuron_core_wb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_core_pkg.sv
// Shared types and constants for the neuron_core Wishbone arbiter.
package neuron_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } nca_state_e;

    localparam logic [31:0] NCA_TO_DATA = 32'hDEAD_0BAD;

    localparam int M0 = 0;
    localparam int M1 = 1;

endpackage

// File: rtl/nca_rr_pick.sv
// Two-way round-robin picker: one-hot grant from a request pair.
// ptr=0 favours master 0 on contention, ptr=1 favours master 1.
module nca_rr_pick
    import neuron_core_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b11) && !ptr: gnt[M0] = 1'b1;
            (req == 2'b11) &&  ptr: gnt[M1] = 1'b1;
            (req == 2'b01):         gnt[M0] = 1'b1;
            (req == 2'b10):         gnt[M1] = 1'b1;
            default:                gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/neuron_core_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of neuron_core.
// Define NCA_TIMEOUT_EN to enable the hung-slave access timeout.
module neuron_core_wb_arbiter
    import neuron_core_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_dat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_dat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_dat_i,
    output logic [1:0]    gnt_o,
    output logic          to_flag_o,
    input  logic          to_clr_i
);

    nca_state_e state;
    logic       ptr;
    logic [1:0] gnt_q;
    logic [1:0] pick;
    logic       to_fire;

    logic            o_cyc, o_stb, o_we;
    logic [DW/8-1:0] o_sel;
    logic [AW-1:0]   o_adr;
    logic [DW-1:0]   o_dat;
    logic            rsp_ack;
    logic [DW-1:0]   rsp_dat;

    nca_rr_pick u_pick (
        .req ({m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i}),
        .ptr (ptr),
        .gnt (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            gnt_q <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick[M0]) begin
                        state <= OWN0;
                        gnt_q <= pick;
                    end else if (pick[M1]) begin
                        state <= OWN1;
                        gnt_q <= pick;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state <= IDLE;
                        ptr   <= 1'b1;
                        gnt_q <= 2'b00;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state <= IDLE;
                        ptr   <= 1'b0;
                        gnt_q <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        o_cyc = 1'b0;
        o_stb = 1'b0;
        o_we  = 1'b0;
        o_sel = '0;
        o_adr = '0;
        o_dat = '0;
        unique case (state)
            OWN0: begin
                o_cyc = m0_cyc_i;
                o_stb = m0_stb_i;
                o_we  = m0_we_i;
                o_sel = m0_sel_i;
                o_adr = m0_adr_i;
                o_dat = m0_dat_i;
            end
            OWN1: begin
                o_cyc = m1_cyc_i;
                o_stb = m1_stb_i;
                o_we  = m1_we_i;
                o_sel = m1_sel_i;
                o_adr = m1_adr_i;
                o_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign s_cyc_o = o_cyc;
    assign s_stb_o = o_stb & ~to_fire;
    assign s_we_o  = o_we;
    assign s_sel_o = o_sel;
    assign s_adr_o = o_adr;
    assign s_dat_o = o_dat;
    assign gnt_o   = gnt_q;

    // Acks with the owner's stb low are stray and never forwarded.
    assign rsp_ack = (o_stb & s_ack_i) | to_fire;
    assign rsp_dat = to_fire ? DW'(NCA_TO_DATA) : s_dat_i;

    assign m0_ack_o = gnt_q[M0] & rsp_ack;
    assign m1_ack_o = gnt_q[M1] & rsp_ack;
    assign m0_dat_o = gnt_q[M0] ? rsp_dat : '0;
    assign m1_dat_o = gnt_q[M1] ? rsp_dat : '0;

`ifdef NCA_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_flag_q;

    assign to_fire   = o_stb && (to_cnt == 16'(TO_CYCLES));
    assign to_flag_o = to_flag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (!o_stb || s_ack_i || to_fire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (to_fire) begin
                to_flag_q <= 1'b1;
            end else if (to_clr_i) begin
                to_flag_q <= 1'b0;
            end
        end
    end
`else
    logic unused_to;

    assign to_fire   = 1'b0;
    assign to_flag_o = 1'b0;
    assign unused_to = to_clr_i ^ (TO_CYCLES == 0);
`endif

endmodule

// File: tb/tb_neuron_core_wb_arbiter.sv
// Directed scoreboard bench for neuron_core_wb_arbiter.
module tb_neuron_core_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt_o;
    logic        to_flag_o;
    logic        to_clr_i;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    neuron_core_wb_arbiter #(
        .AW(32), .DW(32), .TO_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .gnt_o(gnt_o), .to_flag_o(to_flag_o), .to_clr_i(to_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b000;
        {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b000;
        m0_sel_i = 4'hF; m1_sel_i = 4'hF;
        m0_adr_i = '0; m0_dat_i = '0;
        m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i = 1'b0; s_dat_i = '0; to_clr_i = 1'b0;
        repeat (2) step();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_flag", to_flag_o, 1'b0);
        rst = 1'b1;
        step();

        // single master 1 write
        {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b111;
        m1_adr_i = 32'h3000_0004;
        m1_dat_i = 32'h0000_00A5;
        exp_q.push_back(32'h3000_0004);
        exp_q.push_back(32'h0000_00A5);
        #1 chk("wr_pre_gnt", gnt_o, 2'b00);
        step();
        chk("wr_gnt", gnt_o, 2'b10);
        chk("wr_scyc", s_cyc_o, 1'b1);
        chk("wr_swe", s_we_o, 1'b1);
        chk_pop("wr_sadr", s_adr_o);
        chk_pop("wr_sdat", s_dat_o);
        s_ack_i = 1'b1;
        #1 chk("wr_m1ack", m1_ack_o, 1'b1);
        chk("wr_m0ack", m0_ack_o, 1'b0);
        step();
        s_ack_i = 1'b0;
        {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b000;
        #1 chk("wr_m1ack_off", m1_ack_o, 1'b0);
        step();
        chk("wr_release", gnt_o, 2'b00);

        // contention: m0 favoured first
        {m0_cyc_i, m0_stb_i} = 2'b11; m0_adr_i = 32'h3000_0010;
        {m1_cyc_i, m1_stb_i} = 2'b11; m1_adr_i = 32'h3000_0020;
        step();
        chk("ct_gnt0", gnt_o, 2'b01);
        chk("ct_sadr0", s_adr_o, 32'h3000_0010);
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
        exp_q.push_back(32'hCAFE_0001);
        #1 chk("ct_m0ack", m0_ack_o, 1'b1);
        chk_pop("ct_m0dat", m0_dat_o);
        chk("ct_m1ack", m1_ack_o, 1'b0);
        chk("ct_m1dat", m1_dat_o, 32'h0);
        step();
        {m0_cyc_i, m0_stb_i} = 2'b00; s_ack_i = 1'b0;
        step();
        chk("ct_bubble", gnt_o, 2'b00);
        chk("ct_bub_scyc", s_cyc_o, 1'b0);
        step();
        chk("ct_gnt1", gnt_o, 2'b10);
        chk("ct_sadr1", s_adr_o, 32'h3000_0020);
        // owner with stb low: ack must not pass
        m1_stb_i = 1'b0; s_ack_i = 1'b1;
        #1 chk("ack_nostb", m1_ack_o, 1'b0);
        s_ack_i = 1'b0;
        m1_cyc_i = 1'b0;
        step();
        chk("ct_idle", gnt_o, 2'b00);
        {m0_cyc_i, m0_stb_i} = 2'b11;
        {m1_cyc_i, m1_stb_i} = 2'b11;
        step();
        chk("ct_alt", gnt_o, 2'b01);

        // burst of 4 reads with m1 waiting
        for (int i = 0; i < 4; i++) begin
            m0_adr_i = 32'h3000_0100 + 32'(i * 4);
            s_dat_i = 32'h0000_1000 + 32'(i);
            s_ack_i = 1'b1;
            exp_q.push_back(32'h0000_1000 + 32'(i));
            #1 chk("bu_m0ack", m0_ack_o, 1'b1);
            chk_pop("bu_m0dat", m0_dat_o);
            chk("bu_m1ack", m1_ack_o, 1'b0);
            chk("bu_gnt", gnt_o, 2'b01);
            step();
        end
        {m0_cyc_i, m0_stb_i} = 2'b00; s_ack_i = 1'b0;
        #1 chk("bu_hold", gnt_o, 2'b01);
        step();
        chk("bu_bubble", gnt_o, 2'b00);
        step();
        chk("bu_m1gnt", gnt_o, 2'b10);
        {m1_cyc_i, m1_stb_i} = 2'b00;
        step();

        // stray ack in IDLE
        s_ack_i = 1'b1; s_dat_i = 32'hFFFF_FFFF;
        #1 chk("stray_m0ack", m0_ack_o, 1'b0);
        chk("stray_m1ack", m1_ack_o, 1'b0);
        chk("stray_m0dat", m0_dat_o, 32'h0);
        s_ack_i = 1'b0;
        step();

        // stalled read
        {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b110;
        m0_adr_i = 32'h3000_0200;
        step();
        chk("st_gnt", gnt_o, 2'b01);
`ifdef NCA_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            chk("to_wait", m0_ack_o, 1'b0);
            step();
        end
        chk("to_ack", m0_ack_o, 1'b1);
        chk("to_dat", m0_dat_o, 32'hDEAD_0BAD);
        chk("to_sstb", s_stb_o, 1'b0);
        step();
        chk("to_flag", to_flag_o, 1'b1);
        chk("to_ack_off", m0_ack_o, 1'b0);
        chk("to_keep", gnt_o, 2'b01);
        to_clr_i = 1'b1;
        step();
        to_clr_i = 1'b0;
        chk("to_clr", to_flag_o, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            chk("st_wait", m0_ack_o, 1'b0);
            step();
        end
        chk("st_flag", to_flag_o, 1'b0);
        to_clr_i = 1'b1;
        step();
        to_clr_i = 1'b0;
        chk("st_flag_clr", to_flag_o, 1'b0);
`endif

        // reset mid-access
        s_ack_i = 1'b1;
        #1 chk("mr_ack_pre", m0_ack_o, 1'b1);
        rst = 1'b0;
        #1 chk("mr_gnt", gnt_o, 2'b00);
        chk("mr_scyc", s_cyc_o, 1'b0);
        chk("mr_m0ack", m0_ack_o, 1'b0);
        chk("mr_flag", to_flag_o, 1'b0);
        {m0_cyc_i, m0_stb_i} = 2'b00; s_ack_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("mr_after", gnt_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
